// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
// Optional build macro used by sar_adc_ctrl: SAR_CMP_SYNC_EN (two-flop comparator synchroniser).
package sar_adc_pkg;

  // Default result / DAC code width.
  localparam int SAR_WIDTH_DEF  = 8;

  // Default DAC settling cycles per bit trial.
  localparam int SAR_SETTLE_DEF = 16;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_t;

  // Number of edges from the EN-sampling edge to the cycle in which ready_pulse is high.
  function automatic int sar_latency(input int width, input int settle);
    return width * (settle + 1) + 1;
  endfunction

  // Back-to-back conversion period when EN is held high.
  function automatic int sar_period(input int width, input int settle);
    return width * (settle + 1) + 2;
  endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Loadable down-counter that times the DAC settling window of one bit trial.
// done_o is high during the last of SETTLE_CYCLES running cycles after a load.
module sar_settle_timer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic done_o
);

  // Counter holds the number of running cycles still to go after the current one.
  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload at the start of each bit trial, otherwise count down while running.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives an R-2R DAC, reads a comparator,
// produces one WIDTH-bit sample per conversion with a one-cycle ready_pulse.
// Optional build macro: SAR_CMP_SYNC_EN -- when defined, comp_in passes through a
// two-flop synchroniser before the bit decision; otherwise comp_in must be synchronous to clk.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH_DEF,
  parameter int SETTLE_CYCLES = SAR_SETTLE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_out,
  output logic [WIDTH-1:0] Q,
  output logic             ready_pulse,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state_q;
  sar_state_t       state_d;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [IW-1:0]    idx_m1;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] dac_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             rdy_q;
  logic             rdy_d;
  logic             busy_q;
  logic             busy_d;

  logic             cmp_bit;
  logic             tmr_load;
  logic             tmr_run;
  logic             tmr_done;

`ifdef SAR_CMP_SYNC_EN
  logic [1:0] cmp_sync_q;

  // Two-flop synchroniser for an asynchronous comparator; the settle window hides its delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_sync_q <= 2'b00;
    end else begin
      cmp_sync_q <= {cmp_sync_q[0], comp_in};
    end
  end

  assign cmp_bit = cmp_sync_q[1];
`else
  assign cmp_bit = comp_in;
`endif

  assign idx_m1 = idx_q - IW'(1);

  // The timer restarts whenever a new bit trial begins, and only counts in SETTLE.
  assign tmr_load = ((state_q == IDLE) && EN) || ((state_q == DECIDE) && (idx_q != '0));
  assign tmr_run  = (state_q == SETTLE);

  sar_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .load_i(tmr_load),
    .run_i (tmr_run),
    .done_o(tmr_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: EN only matters in IDLE, so a conversion always runs to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (EN) state_d = SETTLE;
      SETTLE:  if (tmr_done) state_d = DECIDE;
      DECIDE:  state_d = (idx_q == '0) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered from these.
  always_comb begin
    dac_d  = dac_q;
    idx_d  = idx_q;
    res_d  = res_q;
    rdy_d  = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        dac_d = '0;
        idx_d = IDX_TOP;
        if (EN) begin
          dac_d = MSB_ONE;
        end
      end
      SETTLE: begin
        dac_d = dac_q;
      end
      DECIDE: begin
        // Keep the trial bit only if Vin is at or above the trial voltage.
        if (!cmp_bit) begin
          dac_d[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
          dac_d[idx_m1] = 1'b1;
          idx_d         = idx_m1;
        end
      end
      DONE: begin
        // Result and pulse land on the same edge; the DAC is parked at zero while idle.
        res_d = dac_q;
        rdy_d = 1'b1;
        dac_d = '0;
        idx_d = IDX_TOP;
      end
      default: begin
        dac_d = '0;
        idx_d = IDX_TOP;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_q  <= '0;
      idx_q  <= IDX_TOP;
      res_q  <= '0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dac_q  <= dac_d;
      idx_q  <= idx_d;
      res_q  <= res_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign dac_out     = dac_q;
  assign Q           = res_q;
  assign ready_pulse = rdy_q;
  assign busy        = busy_q;

endmodule
